sync_ptr_multi: RTL and testbench

Parametrised multi-channel synchroniser for Gray-coded async-FIFO pointers crossing into the clk domain. Each channel has a configurable-depth flop chain, an optional registered Gray-to-binary output, a change-strobe and a multi-bit-transition error detector. A warm-up counter qualifies the outputs after reset. This block is the successor to the fixed two-flop, single-pointer synchroniser in the AXI clock-crossing path.

---
 rtl/sync_ptr_multi.sv | 180 ++++++++++++++++++
 tb/tb_sync_ptr_multi.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_ptr_multi.sv
//------------------------------------------------------------------------------
// sync_ptr_multi
//
// Multi-channel synchroniser for Gray-coded async-FIFO pointers entering the
// clk domain. Each channel passes through a STAGES-deep flop chain. The last
// stage of the chain is sync_gray. Three registered outputs are derived from
// sync_gray and from a one-edge-delayed copy of it (the prev register):
//   * sync_bin : binary equivalent of sync_gray (when GRAY2BIN=1)
//   * ptr_chg  : one-cycle strobe when the synchronised pointer moves
//   * err      : sticky flag raised when one move flips more than one bit
//                (when CHECK=1)
// A warm-up counter holds sync_valid low until every chain stage and the prev
// register hold data sampled after reset. Until then ptr_chg and err are
// masked, so transitions flushed out of the reset state are ignored.
//
// Ports
//   clk         destination-domain clock
//   rst         asynchronous, active-high reset
//   ptr_gray    NCH Gray pointers, ASIZE+1 bits each, asynchronous to clk
//   err_clr     synchronous clear of all err bits (a set on the same edge wins)
//   sync_gray   synchronised Gray pointers (last chain stage)
//   sync_bin    registered binary equivalent of sync_gray
//   ptr_chg     per-channel change strobe, qualified by sync_valid
//   sync_valid  outputs are qualified (warm-up complete)
//   err         per-channel sticky multi-bit-transition flag
//------------------------------------------------------------------------------
module sync_ptr_multi #(
   parameter int ASIZE    = 4,
   parameter int NCH      = 1,
   parameter int STAGES   = 2,
   parameter int GRAY2BIN = 1,
   parameter int CHECK    = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NCH*(ASIZE+1)-1:0] ptr_gray,
   input  logic                     err_clr,
   output logic [NCH*(ASIZE+1)-1:0] sync_gray,
   output logic [NCH*(ASIZE+1)-1:0] sync_bin,
   output logic [NCH-1:0]           ptr_chg,
   output logic                     sync_valid,
   output logic [NCH-1:0]           err
);

   localparam int W  = ASIZE + 1;
   localparam int PW = NCH * W;
   localparam int CW = $clog2(STAGES + 2);

   // Count value at which every chain stage and prev hold post-reset samples.
   localparam logic [CW-1:0] WARM_DONE = CW'(STAGES + 1);

   // Depths below 2 do not give metastability protection, and depths above
   // 4 are not characterised for this block.
   generate
      if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
         $error("sync_ptr_multi: STAGES must be in the range 2..4");
      end
   endgenerate

   //---------------------------------------------------------------------------
   // Synchroniser chain: one plain shift register per bit. There is no enable
   // and no logic between stages, so the tools keep the flops back to back.
   // chain_reg[0] is the metastable capture stage.
   //---------------------------------------------------------------------------
   logic [STAGES-1:0][PW-1:0] chain_reg;
   logic [PW-1:0]             prev_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chain_reg <= '0;
      end else begin
         chain_reg <= {chain_reg[STAGES-2:0], ptr_gray};
      end
   end

   assign sync_gray = chain_reg[STAGES-1];

   // prev trails sync_gray by one edge; differences between the two mark a move.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_reg <= '0;
      end else begin
         prev_reg <= sync_gray;
      end
   end

   //---------------------------------------------------------------------------
   // Warm-up counter: runs 0..STAGES+1 after reset release, then saturates.
   //---------------------------------------------------------------------------
   logic [CW-1:0] warm_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         warm_reg <= '0;
      end else if (warm_reg != WARM_DONE) begin
         warm_reg <= warm_reg + 1'b1;
      end
   end

   assign sync_valid = (warm_reg == WARM_DONE);

   //---------------------------------------------------------------------------
   // Per-channel derived outputs
   //---------------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < NCH; gi++) begin : g_ch
         logic [W-1:0] cur_gray;
         logic [W-1:0] diff;
         logic         chg_reg;

         assign cur_gray = sync_gray[gi*W +: W];
         assign diff     = cur_gray ^ prev_reg[gi*W +: W];

         // Change strobe. The sync_valid seen here is the value before the
         // edge, which keeps the last flushed reset transition masked.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               chg_reg <= 1'b0;
            end else begin
               chg_reg <= sync_valid && (diff != '0);
            end
         end

         assign ptr_chg[gi] = chg_reg;

         if (GRAY2BIN != 0) begin : g_bin
            logic [W-1:0] bin_next;
            logic [W-1:0] bin_reg;

            // Prefix XOR from the MSB down: b[i] = g[MSB] ^ ... ^ g[i].
            always_comb begin
               logic acc;
               acc      = 1'b0;
               bin_next = '0;
               for (int i = W - 1; i >= 0; i--) begin
                  acc         = acc ^ cur_gray[i];
                  bin_next[i] = acc;
               end
            end

            always_ff @(posedge clk or posedge rst) begin
               if (rst) begin
                  bin_reg <= '0;
               end else begin
                  bin_reg <= bin_next;
               end
            end

            assign sync_bin[gi*W +: W] = bin_reg;
         end else begin : g_no_bin
            assign sync_bin[gi*W +: W] = '0;
         end

         if (CHECK != 0) begin : g_chk
            logic multi;
            logic err_reg;

            // More than one bit set <=> clearing the lowest set bit leaves
            // something behind.
            assign multi = ((diff & (diff - W'(1))) != '0);

            // The set term is ORed in last, so a set on the same edge as a
            // clear leaves the flag set.
            always_ff @(posedge clk or posedge rst) begin
               if (rst) begin
                  err_reg <= 1'b0;
               end else begin
                  err_reg <= (sync_valid && multi) || (err_reg && !err_clr);
               end
            end

            assign err[gi] = err_reg;
         end else begin : g_no_chk
            assign err[gi] = 1'b0;
         end
      end
   endgenerate

endmodule

// File: tb/tb_sync_ptr_multi.sv
module tb_sync_ptr_multi;

   localparam int ASIZE = 4;
   localparam int NCH   = 3;
   localparam int W     = ASIZE + 1;
   localparam int PW    = NCH * W;
   localparam int SA    = 2;
   localparam int SB    = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          err_clr = 1'b0;
   logic [PW-1:0] ptr_gray = '0;

   logic [PW-1:0]  a_gray, a_bin, b_gray, b_bin;
   logic [NCH-1:0] a_chg, a_err, b_chg, b_err;
   logic           a_valid, b_valid;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   sync_ptr_multi #(.ASIZE(ASIZE), .NCH(NCH), .STAGES(SA), .GRAY2BIN(1), .CHECK(1)) dut_a (
      .clk(clk), .rst(rst), .ptr_gray(ptr_gray), .err_clr(err_clr),
      .sync_gray(a_gray), .sync_bin(a_bin), .ptr_chg(a_chg),
      .sync_valid(a_valid), .err(a_err)
   );

   sync_ptr_multi #(.ASIZE(ASIZE), .NCH(NCH), .STAGES(SB), .GRAY2BIN(1), .CHECK(1)) dut_b (
      .clk(clk), .rst(rst), .ptr_gray(ptr_gray), .err_clr(err_clr),
      .sync_gray(b_gray), .sync_bin(b_bin), .ptr_chg(b_chg),
      .sync_valid(b_valid), .err(b_err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   //---------------------------------------------------------------------------
   // Reference model: history of the input sampled at each edge since reset
   // release. With depth s, sync_gray after edge k is the sample from edge
   // k-s+1 (zero before that). Everything else follows from that sequence.
   //---------------------------------------------------------------------------
   logic [PW-1:0]  hist [8192];
   logic           clr_hist [8192];
   int             n = 0;
   logic [NCH-1:0] err_exp_a = '0;
   logic [NCH-1:0] err_exp_b = '0;

   function automatic logic [PW-1:0] sg(input int k, input int s);
      if (k >= s) return hist[k - s + 1];
      return '0;
   endfunction

   function automatic logic [PW-1:0] g2b_all(input logic [PW-1:0] g);
      logic [PW-1:0] r;
      logic [W-1:0]  gc, b;
      r = '0;
      for (int c = 0; c < NCH; c++) begin
         gc = g[c*W +: W];
         b  = gc;
         for (int sh = 1; sh < W; sh++) b = b ^ (gc >> sh);
         r[c*W +: W] = b;
      end
      return r;
   endfunction

   function automatic logic [4:0] gray5(input int b);
      return 5'(b ^ (b >> 1));
   endfunction

   task automatic model_check(input int s, input string tag,
                              input logic [PW-1:0] gray, input logic [PW-1:0] bin,
                              input logic [NCH-1:0] chg, input logic valid,
                              input logic [NCH-1:0] errv, inout logic [NCH-1:0] err_exp);
      logic [PW-1:0]  p1, p2;
      logic [NCH-1:0] chg_e;
      logic [W-1:0]   d;
      logic           vp;
      p1 = sg(n - 1, s);
      p2 = sg(n - 2, s);
      vp = (n - 1 >= s + 1);
      for (int c = 0; c < NCH; c++) begin
         d          = p1[c*W +: W] ^ p2[c*W +: W];
         chg_e[c]   = vp && (d != 0);
         err_exp[c] = (vp && ($countones(d) > 1)) || (err_exp[c] && !clr_hist[n]);
      end
      chk({tag, "_gray"},  32'(gray),  32'(sg(n, s)));
      chk({tag, "_bin"},   32'(bin),   32'(g2b_all(p1)));
      chk({tag, "_chg"},   32'(chg),   32'(chg_e));
      chk({tag, "_valid"}, 32'(valid), 32'(n >= s + 1));
      chk({tag, "_err"},   32'(errv),  32'(err_exp));
   endtask

   task automatic zero_checks(input string tag);
      chk({tag, "_a_gray"},  32'(a_gray),  0);
      chk({tag, "_a_bin"},   32'(a_bin),   0);
      chk({tag, "_a_chg"},   32'(a_chg),   0);
      chk({tag, "_a_valid"}, 32'(a_valid), 0);
      chk({tag, "_a_err"},   32'(a_err),   0);
      chk({tag, "_b_gray"},  32'(b_gray),  0);
      chk({tag, "_b_bin"},   32'(b_bin),   0);
      chk({tag, "_b_chg"},   32'(b_chg),   0);
      chk({tag, "_b_valid"}, 32'(b_valid), 0);
      chk({tag, "_b_err"},   32'(b_err),   0);
   endtask

   // Compare process: every edge, 1 time unit after it.
   always @(posedge clk) begin
      if (rst) begin
         n         = 0;
         err_exp_a = '0;
         err_exp_b = '0;
      end else begin
         n            = n + 1;
         hist[n]      = ptr_gray;
         clr_hist[n]  = err_clr;
      end
      #1;
      if (rst) begin
         zero_checks("rst");
      end else begin
         model_check(SA, "mdl_a", a_gray, a_bin, a_chg, a_valid, a_err, err_exp_a);
         model_check(SB, "mdl_b", b_gray, b_bin, b_chg, b_valid, b_err, err_exp_b);
      end
   end

   task automatic at_edge();
      @(posedge clk);
      #2;
   endtask

   //---------------------------------------------------------------------------
   // Directed scenarios followed by randomized traffic
   //---------------------------------------------------------------------------
   initial begin
      int         pulses;
      logic [4:0] seq [5];
      logic [4:0] ch1_bin;
      int         bin_cur [NCH];
      int         r;
      int         k;

      // Reset / warm-up: ch0 = 00011 held, ch1 = ch2 = 00000.
      ptr_gray = {5'b00000, 5'b00000, 5'b00011};
      repeat (3) @(negedge clk);
      rst = 1'b0;
      at_edge();                                  // edge 1
      chk("warm_e1_a_valid", 32'(a_valid), 0);
      at_edge();                                  // edge 2
      chk("warm_e2_a_gray0", 32'(a_gray[4:0]), 32'h03);
      chk("warm_e2_a_valid", 32'(a_valid), 0);
      at_edge();                                  // edge 3
      chk("warm_e3_a_bin0",  32'(a_bin[4:0]), 32'h02);
      chk("warm_e3_a_valid", 32'(a_valid), 1);
      chk("warm_e3_b_valid", 32'(b_valid), 0);
      at_edge();                                  // edge 4
      chk("warm_e4_b_valid", 32'(b_valid), 1);
      repeat (4) begin
         at_edge();
         chk("warm_a_chg", 32'(a_chg), 0);
         chk("warm_a_err", 32'(a_err), 0);
         chk("warm_b_chg", 32'(b_chg), 0);
      end

      // Latency with depth 3: ch2 00000 -> 00001 before edge E.
      @(negedge clk);
      ptr_gray[14:10] = 5'b00001;
      at_edge();                                  // E
      chk("lat_e0_b_gray2", 32'(b_gray[14:10]), 0);
      at_edge();                                  // E+1
      chk("lat_e1_b_gray2", 32'(b_gray[14:10]), 0);
      at_edge();                                  // E+2
      chk("lat_e2_b_gray2", 32'(b_gray[14:10]), 1);
      chk("lat_e2_b_chg2",  32'(b_chg[2]), 0);
      at_edge();                                  // E+3
      chk("lat_e3_b_bin2",  32'(b_bin[14:10]), 1);
      chk("lat_e3_b_chg2",  32'(b_chg[2]), 1);
      at_edge();                                  // E+4
      chk("lat_e4_b_chg2",  32'(b_chg[2]), 0);

      // Wrap on ch0: park at binary 27 (a multi-bit jump), clear err, then
      // count 28..31 -> 0 one step every 4 cycles.
      @(negedge clk);
      ptr_gray[4:0] = gray5(27);
      repeat (8) @(negedge clk);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      at_edge();
      chk("wrap_pre_a_err0", 32'(a_err[0]), 0);
      pulses = 0;
      for (int st = 0; st < 5; st++) begin
         @(negedge clk);
         ptr_gray[4:0] = gray5((28 + st) % 32);
         repeat (4) begin
            at_edge();
            if (a_chg[0]) begin
               if (pulses < 5) seq[pulses] = a_bin[4:0];
               pulses++;
            end
         end
      end
      repeat (4) begin
         at_edge();
         if (a_chg[0]) begin
            if (pulses < 5) seq[pulses] = a_bin[4:0];
            pulses++;
         end
      end
      chk("wrap_pulses", 32'(pulses), 5);
      for (int i = 0; i < 5; i++) chk("wrap_bin_seq", 32'(seq[i]), 32'((28 + i) % 32));
      chk("wrap_a_err0", 32'(a_err[0]), 0);
      chk("wrap_b_err0", 32'(b_err[0]), 0);

      // Multi-bit error on ch0: 00000 -> 00011 before edge E.
      @(negedge clk);
      ptr_gray[4:0] = 5'b00011;
      at_edge();                                  // E
      at_edge();                                  // E+1
      chk("mb_e1_a_gray0", 32'(a_gray[4:0]), 32'h03);
      chk("mb_e1_a_err0",  32'(a_err[0]), 0);
      at_edge();                                  // E+2
      chk("mb_e2_a_err0",  32'(a_err[0]), 1);
      repeat (4) at_edge();
      chk("mb_hold_a_err0", 32'(a_err[0]), 1);
      @(negedge clk);
      err_clr = 1'b1;
      at_edge();
      chk("mb_clr_a_err0", 32'(a_err[0]), 0);
      chk("mb_clr_b_err0", 32'(b_err[0]), 0);
      @(negedge clk);
      err_clr = 1'b0;

      // Set and clear on the same edge: 00011 -> 00000, clear at E+2.
      @(negedge clk);
      ptr_gray[4:0] = 5'b00000;
      @(negedge clk);
      @(negedge clk);
      err_clr = 1'b1;
      at_edge();                                  // E+2
      chk("mb_same_a_err0", 32'(a_err[0]), 1);
      @(negedge clk);
      err_clr = 1'b0;
      at_edge();
      chk("mb_after_a_err0", 32'(a_err[0]), 1);
      chk("mb_after_b_err0", 32'(b_err[0]), 1);
      repeat (2) @(negedge clk);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;

      // Multi-channel: ch0 00000 -> 00001, ch2 00001 -> 00011, ch1 held.
      repeat (4) @(negedge clk);
      ch1_bin = a_bin[9:5];
      ptr_gray[4:0]   = 5'b00001;
      ptr_gray[14:10] = 5'b00011;
      at_edge();                                  // E
      at_edge();                                  // E+1
      at_edge();                                  // E+2
      chk("mc_e2_a_chg", 32'(a_chg), 32'h5);
      at_edge();                                  // E+3
      chk("mc_e3_a_chg",  32'(a_chg), 0);
      chk("mc_e3_b_chg",  32'(b_chg), 32'h5);
      chk("mc_e3_a_bin1", 32'(a_bin[9:5]), 32'(ch1_bin));
      chk("mc_e3_a_bin2", 32'(a_bin[14:10]), 32'h02);

      // Randomized traffic with an asynchronous reset in the middle.
      for (int c = 0; c < NCH; c++) bin_cur[c] = 0;
      for (int i = 0; i < 1500; i++) begin
         @(negedge clk);
         if (i == 703) rst = 1'b0;
         for (int c = 0; c < NCH; c++) begin
            r = $urandom_range(0, 15);
            if (r < 6)       bin_cur[c] = (bin_cur[c] + 1) % 32;
            else if (r < 9)  bin_cur[c] = (bin_cur[c] + 31) % 32;
            else if (r == 15) bin_cur[c] = $urandom_range(0, 31);
            ptr_gray[c*W +: W] = gray5(bin_cur[c]);
         end
         err_clr = ($urandom_range(0, 19) == 0);
         if (i == 700) begin
            #2;
            rst = 1'b1;
            #1;
            zero_checks("arst");
         end
         if (i >= 703 && i <= 707) begin
            at_edge();
            k = i - 702;
            chk("rewarm_a_valid", 32'(a_valid), 32'(k >= SA + 1));
            chk("rewarm_b_valid", 32'(b_valid), 32'(k >= SB + 1));
            if (k <= SA + 1) chk("rewarm_a_chg", 32'(a_chg), 0);
         end
      end

      err_clr = 1'b0;
      repeat (5) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
